// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// funct codes, ALU operations and datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_RTYPE_EX = 4'd3,
        ST_RTYPE_WB = 4'd4,
        ST_MEM_ADR  = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WB   = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_BR_EX    = 4'd9,
        ST_ADDI_EX  = 4'd10,
        ST_ADDI_WB  = 4'd11,
        ST_JUMP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mips_mc_ctrl_alu_dec.sv
// R-type funct decoder: ALU operation plus flags for nop and unsupported funct.
module mips_alu_dec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       funct_nop,
    output logic       funct_illegal
);

    always_comb begin
        alu_ctrl      = ALU_ADD;
        funct_nop     = 1'b0;
        funct_illegal = 1'b0;
        case (funct)
            FN_ADD, FN_ADDU: alu_ctrl = ALU_ADD;
            FN_SUB, FN_SUBU: alu_ctrl = ALU_SUB;
            FN_AND:          alu_ctrl = ALU_AND;
            FN_OR:           alu_ctrl = ALU_OR;
            FN_NOR:          alu_ctrl = ALU_NOR;
            FN_SLT:          alu_ctrl = ALU_SLT;
            FN_SLL:          funct_nop = 1'b1;
            default:         funct_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/writeback over a
// shared datapath and counts retired instructions.
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_ctrl,
    output logic [1:0]       pc_src,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_o
);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_retired;
    logic             w_retire;
    logic [3:0]       w_dec_alu_ctrl;
    logic             w_funct_nop;
    logic             w_funct_illegal;

    mips_alu_dec u_alu_dec (
        .funct         (funct),
        .alu_ctrl      (w_dec_alu_ctrl),
        .funct_nop     (w_funct_nop),
        .funct_illegal (w_funct_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        pc_en        = 1'b0;
        iord         = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_B;
        alu_ctrl     = ALU_AND;
        pc_src       = PCSRC_ALU;
        illegal_op   = 1'b0;
        case (r_state)
            ST_IDLE: w_next_state = ST_FETCH;
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_ctrl  = ALU_ADD;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                if (mem_ready) w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                // Branch target computed speculatively into ALUOut.
                alu_src_b = SRCB_IMM_SH;
                alu_ctrl  = ALU_ADD;
                case (opcode)
                    OP_RTYPE:         w_next_state = ST_RTYPE_EX;
                    OP_LW, OP_SW:     w_next_state = ST_MEM_ADR;
                    OP_BEQ, OP_BNE:   w_next_state = ST_BR_EX;
                    OP_ADDI, OP_ADDIU: w_next_state = ST_ADDI_EX;
                    OP_J:             w_next_state = ST_JUMP;
                    default: begin
                        illegal_op   = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                endcase
            end
            ST_RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_ctrl  = w_dec_alu_ctrl;
                if (w_funct_nop) begin
                    w_retire     = 1'b1;
                    w_next_state = ST_FETCH;
                end else if (w_funct_illegal) begin
                    illegal_op   = 1'b1;
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_RTYPE_WB;
                end
            end
            ST_RTYPE_WB: begin
                reg_dst      = 1'b1;
                reg_write    = 1'b1;
                w_retire     = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_MEM_ADR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_IMM;
                alu_ctrl     = ALU_ADD;
                w_next_state = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) w_next_state = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                mem_to_reg   = 1'b1;
                reg_write    = 1'b1;
                w_retire     = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    w_retire     = 1'b1;
                    w_next_state = ST_FETCH;
                end
            end
            ST_BR_EX: begin
                alu_src_a    = 1'b1;
                alu_ctrl     = ALU_SUB;
                pc_src       = PCSRC_ALUOUT;
                pc_en        = (opcode == OP_BNE) ? !zero : zero;
                w_retire     = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_ADDI_EX: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_IMM;
                alu_ctrl     = ALU_ADD;
                w_next_state = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                reg_write    = 1'b1;
                w_retire     = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_JUMP: begin
                pc_src       = PCSRC_JUMP;
                pc_en        = 1'b1;
                w_retire     = 1'b1;
                w_next_state = ST_FETCH;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign retired = r_retired;
    assign state_o = r_state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: walks each instruction class through the FSM
// and compares strobes, state and retired count against hand-derived values.
module tb_mips_mc_ctrl;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
        S_RTYPE_EX = 4'd3, S_RTYPE_WB = 4'd4, S_MEM_ADR = 4'd5, S_MEM_RD = 4'd6,
        S_MEM_WB = 4'd7, S_MEM_WR = 4'd8, S_BR_EX = 4'd9, S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11, S_JUMP = 4'd12;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
    logic        mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, pc_src;
    logic [3:0]  alu_ctrl, state_o;
    logic [31:0] retired;
    logic [17:0] all_outs;

    int checks   = 0;
    int failures = 0;

    mips_mc_ctrl #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .pc_src     (pc_src),
        .illegal_op (illegal_op),
        .retired    (retired),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    assign all_outs = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                       reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal_op};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [31:0] ir);
        opcode = ir[31:26];
        funct  = ir[5:0];
    endtask

    initial begin
        rst = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = '0; funct = '0;
        repeat (3) step();
        check("rst_state", 32'(state_o), 32'(S_IDLE));
        check("rst_outs", 32'(all_outs), 32'd0);
        check("rst_retired", retired, 32'd0);

        rst = 1'b1;
        check("idle_hold", 32'(state_o), 32'(S_IDLE));
        step();
        check("fetch_state", 32'(state_o), 32'(S_FETCH));
        check("fetch_rd_iord_irw_pcen", {28'd0, mem_read, iord, ir_write, pc_en}, 32'b1011);
        check("fetch_alu", {26'd0, alu_src_a, alu_src_b, alu_ctrl[2:0]}, {26'd0, 1'b0, 2'd1, 3'b010});

        // add r1,r2,r3
        load_ir(32'h00430820);
        step(); check("add_decode", {24'd0, state_o, 2'd0, alu_src_b}, {24'd0, S_DECODE, 2'd0, 2'd3});
        step(); check("add_ex", {24'd0, state_o, alu_ctrl}, {24'd0, S_RTYPE_EX, 4'b0010});
        check("add_ex_srca", 32'(alu_src_a), 32'd1);
        step(); check("add_wb", {24'd0, state_o, 2'd0, reg_dst, reg_write}, {24'd0, S_RTYPE_WB, 4'b0011});
        step(); check("add_fetch", 32'(state_o), 32'(S_FETCH));
        check("add_retired", retired, 32'd1);

        // lw with two wait cycles in MEM_RD
        load_ir(32'h8C220000);
        step(); check("lw_decode", 32'(state_o), 32'(S_DECODE));
        step(); check("lw_adr", {24'd0, state_o, 2'd0, alu_src_b}, {24'd0, S_MEM_ADR, 2'd0, 2'd2});
        step(); mem_ready = 1'b0;
        check("lw_rd0", {24'd0, state_o, 2'd0, mem_read, iord}, {24'd0, S_MEM_RD, 4'b0011});
        step(); check("lw_rd1", {24'd0, state_o, 2'd0, mem_read, iord}, {24'd0, S_MEM_RD, 4'b0011});
        step(); mem_ready = 1'b1;
        check("lw_rd2", {24'd0, state_o, 2'd0, mem_read, iord}, {24'd0, S_MEM_RD, 4'b0011});
        step(); check("lw_wb", {24'd0, state_o, 2'd0, mem_to_reg, reg_write}, {24'd0, S_MEM_WB, 4'b0011});
        check("lw_wb_regdst", 32'(reg_dst), 32'd0);
        step(); check("lw_fetch", 32'(state_o), 32'(S_FETCH));
        check("lw_retired", retired, 32'd2);

        // beq taken, beq not taken, bne not-equal
        load_ir(32'h10220001); zero = 1'b1;
        step(); step();
        check("beq_t", {24'd0, state_o, alu_ctrl}, {24'd0, S_BR_EX, 4'b0110});
        check("beq_t_pc", {29'd0, pc_en, pc_src}, {29'd0, 1'b1, 2'd1});
        step(); check("beq_t_fetch", 32'(state_o), 32'(S_FETCH));
        zero = 1'b0;
        step(); step();
        check("beq_nt_pc", {29'd0, pc_en, pc_src}, {29'd0, 1'b0, 2'd1});
        step(); check("beq_nt_retired", retired, 32'd4);
        load_ir(32'h14220001);
        step(); step();
        check("bne_pc", 32'(pc_en), 32'd1);
        step(); check("bne_retired", retired, 32'd5);

        // j
        load_ir(32'h08000004);
        step(); step();
        check("j_state", 32'(state_o), 32'(S_JUMP));
        check("j_pc", {29'd0, pc_en, pc_src}, {29'd0, 1'b1, 2'd2});
        step(); check("j_fetch", 32'(state_o), 32'(S_FETCH));
        check("j_retired", retired, 32'd6);

        // addi
        load_ir(32'h20410005);
        step(); step();
        check("addi_ex", {24'd0, state_o, 2'd0, alu_src_b}, {24'd0, S_ADDI_EX, 2'd0, 2'd2});
        step(); check("addi_wb", {24'd0, state_o, 2'd0, reg_dst, reg_write}, {24'd0, S_ADDI_WB, 4'b0001});
        step(); check("addi_retired", retired, 32'd7);

        // illegal opcode: one pulse in DECODE, no retire
        opcode = 6'h3F; funct = 6'h00;
        step(); check("ill_op_pulse", {24'd0, state_o, 3'd0, illegal_op}, {24'd0, S_DECODE, 4'd1});
        step(); check("ill_op_fetch", {24'd0, state_o, 3'd0, illegal_op}, {24'd0, S_FETCH, 4'd0});
        check("ill_op_retired", retired, 32'd7);

        // illegal funct inside RTYPE_EX
        load_ir(32'h0043083F);
        step(); step();
        check("ill_fn_pulse", {24'd0, state_o, 3'd0, illegal_op}, {24'd0, S_RTYPE_EX, 4'd1});
        step(); check("ill_fn_retired", {24'd0, state_o, 4'd0} | retired, {24'd0, S_FETCH, 4'd0} | 32'd7);

        // nop retires without writing
        load_ir(32'h00000000);
        step(); step();
        check("nop_ex", {24'd0, state_o, 2'd0, reg_write, illegal_op}, {24'd0, S_RTYPE_EX, 4'd0});
        step(); check("nop_fetch", 32'(state_o), 32'(S_FETCH));
        check("nop_retired", retired, 32'd8);

        // sw completing after one wait cycle
        load_ir(32'hAC220000);
        step(); step(); step(); mem_ready = 1'b0;
        check("sw_wr0", {24'd0, state_o, 2'd0, mem_write, iord}, {24'd0, S_MEM_WR, 4'b0011});
        step(); mem_ready = 1'b1;
        check("sw_wr1", {24'd0, state_o, 2'd0, mem_write, mem_read}, {24'd0, S_MEM_WR, 4'b0010});
        step(); check("sw_fetch", 32'(state_o), 32'(S_FETCH));
        check("sw_retired", retired, 32'd9);

        // reset in the middle of a store wait
        step(); step(); step(); mem_ready = 1'b0;
        check("swr_wr", 32'(state_o), 32'(S_MEM_WR));
        rst = 1'b0;
        step(); check("swr_idle", {24'd0, state_o, 3'd0, mem_write}, {24'd0, S_IDLE, 4'd0});
        check("swr_outs", 32'(all_outs), 32'd0);
        check("swr_retired", retired, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Multi-cycle control unit that sequences the shared MIPS datapath (single memory port, register bank, ALU, PC/IR registers) one instruction at a time. It is a Moore/Mealy FSM driven by IR opcode/funct, the ALU zero flag and a memory-ready handshake. It also counts retired instructions. It sits inside the MIPS top level beside the register bank and memories.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the access requested this cycle
pc_en  out  1  PC register load enable
iord  out  1  0=PC addresses memory, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load enable
reg_dst  out  1  0=rt, 1=rd write index
mem_to_reg  out  1  0=ALUOut, 1=MDR write data
reg_write  out  1  register bank write enable
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
alu_ctrl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
pc_src  out  2  0=ALU result, 1=ALUOut, 2=jump target
illegal_op  out  1  one-cycle pulse, unsupported opcode/funct
retired  out  CNT_W  instructions completed
state_o  out  4  current state, debug

Behaviour:
- Reset (rst=0 at edge): state=IDLE, retired=0. In IDLE every output is 0, except state_o, which shows the IDLE code. The FSM leaves IDLE on the first edge with rst=1. Reset asserted in any state aborts the instruction; no write strobe is raised in the cycle after that edge.
- Outputs are decoded from the state; pc_en, ir_write and mem_to_reg-related writes are also qualified by mem_ready and zero as listed. All outputs not listed for a state are 0.
- IDLE -> FETCH.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_ctrl=ADD, pc_src=0.
  - ir_write=pc_en=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=3, alu_ctrl=ADD (branch target into ALUOut). Next state by opcode:
  - 0x00 -> RTYPE_EX
  - 0x23 -> MEM_ADR
  - 0x2B -> MEM_ADR
  - 0x04, 0x05 -> BR_EX
  - 0x08, 0x09 -> ADDI_EX
  - 0x02 -> JUMP
  - other -> FETCH, with illegal_op=1
- RTYPE_EX: alu_src_a=1, alu_src_b=0, alu_ctrl from funct:
  - 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT.
  - Funct 0x00 (nop/sll encoding) is treated as retire-only: go to FETCH with no writes, retired+1.
  - Any other funct: illegal_op=1 -> FETCH.
  - Otherwise -> RTYPE_WB.
- RTYPE_WB: reg_dst=1, reg_write=1, mem_to_reg=0 -> FETCH.
- MEM_ADR: alu_src_a=1, alu_src_b=2, ADD. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: iord=1, mem_read=1. Held until mem_ready; then -> MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
- MEM_WR: iord=1, mem_write=1. Held until mem_ready; then -> FETCH. mem_write stays high for the whole wait.
- BR_EX: alu_src_a=1, alu_src_b=0, SUB, pc_src=1.
  - pc_en = zero for beq (0x04); pc_en = !zero for bne (0x05).
  - -> FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=2, ADD -> ADDI_WB.
- ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
- JUMP: pc_src=2, pc_en=1 -> FETCH.
- retired increments by 1 on every transition into FETCH from a completing state (RTYPE_WB, MEM_WB, MEM_WR done, BR_EX, ADDI_WB, JUMP, nop). It does not increment on an illegal_op exit. The counter wraps modulo 2^CNT_W.
- Latency with mem_ready=1 (cycles FETCH to next FETCH): R-type 4, lw 5, sw 4, beq/bne 3, addi 4, j 3. Each memory wait cycle adds 1.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state enum typedef;
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_J;
  - funct constants;
  - alu_ctrl constants;
  - alu_src_b / pc_src encodings.
- One sub-module, mips_alu_dec: combinational funct -> alu_ctrl plus funct_illegal. The FSM overrides its result with ADD or SUB outside RTYPE_EX.

Test Plan:
- Reset: hold rst=0 for 3 clk, with mem_ready=1 -> all outputs 0, retired=0. Release rst -> IDLE for one cycle, then FETCH with mem_read=1, iord=0.
- IR=0x00430820 (add r1,r2,r3), mem_ready=1 -> states FETCH, DECODE, RTYPE_EX (alu_ctrl=0010), RTYPE_WB (reg_dst=1, reg_write=1). Back in FETCH after 4 cycles; retired=1.
- IR=0x8C220000 (lw) with mem_ready low for 2 cycles in MEM_RD -> mem_read and iord stay 1 for 3 cycles. MEM_WB asserts mem_to_reg=1, reg_write=1. Total 7 cycles.
- IR=0x10220001 (beq): zero=1 -> pc_en=1, pc_src=1 in BR_EX. Repeat with zero=0 -> pc_en=0. Both take 3 cycles.
- IR=0x08000004 (j) -> JUMP asserts pc_src=2, pc_en=1. Next cycle is FETCH; retired +1.
- IR opcode 0x3F -> illegal_op pulses exactly once in DECODE, then FETCH, and retired is unchanged. Separately, assert rst=0 during MEM_WR -> the next cycle is IDLE with mem_write=0.
